// File: rtl/cp_imem_resp.sv
// Fetch-side instruction memory responder: fixed-latency read pipe into a credit-guarded response FIFO.
// Optional CP_IMEM_ERR_EN adds instr_err_o for misaligned or out-of-range fetch addresses.
module cp_imem_resp #(
  parameter int    DEPTH      = 1024,
  parameter int    LATENCY    = 1,
  parameter int    RESP_DEPTH = 2,
  parameter string INIT_FILE  = "",
  localparam int   AW         = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_ready_i,
  input  logic [31:0]   instr_addr_i,
  output logic          instr_valid_o,
  output logic [31:0]   instr_data_o,
`ifdef CP_IMEM_ERR_EN
  output logic          instr_err_o,
`endif
  input  logic          ld_we_i,
  input  logic [AW-1:0] ld_addr_i,
  input  logic [31:0]   ld_data_i
);

`ifdef CP_IMEM_ERR_EN
  localparam int W = 33;
`else
  localparam int W = 32;
`endif
  localparam int PW = $clog2(RESP_DEPTH);
  localparam int CW = $clog2(RESP_DEPTH + 1);
  localparam int IW = $clog2(LATENCY + 1);
  localparam int TW = $clog2(RESP_DEPTH + LATENCY + 1) + 1;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] rd_idx;
  logic [W-1:0]  rd_word;
  logic          issue, push, pop, full;
  logic [W-1:0]  push_word;
  logic [IW-1:0] inflight;
  logic [CW-1:0] count;
  logic [PW-1:0] wptr, rptr;
  logic [W-1:0]  fifo_q [RESP_DEPTH];
  logic [W-1:0]  head;
  logic [TW-1:0] used;

  always_ff @(posedge clk) begin
    if (ld_we_i) mem[ld_addr_i] <= ld_data_i;
  end

  // Combinational read in the issue cycle: a same-cycle load lands at the edge, so the read sees old data.
  assign rd_idx = instr_addr_i[AW+1:2];
`ifdef CP_IMEM_ERR_EN
  logic addr_err;
  assign addr_err = (|instr_addr_i[1:0]) | (|instr_addr_i[31:AW+2]);
  assign rd_word  = addr_err ? {1'b1, 32'h0} : {1'b0, mem[rd_idx]};
`else
  logic unused_addr;
  assign unused_addr = ^{instr_addr_i[31:AW+2], instr_addr_i[1:0]};
  assign rd_word     = mem[rd_idx];
`endif

  // Credits: every in-flight word already owns a FIFO slot, so the pipe never has to stall.
  assign pop   = instr_valid_o & instr_ready_i;
  assign used  = TW'(inflight) + TW'(count) - TW'(pop);
  assign issue = instr_ready_i & (used < TW'(RESP_DEPTH));

  if (LATENCY == 1) begin : g_lat1
    assign push      = issue;
    assign push_word = rd_word;
  end else begin : g_latn
    logic [LATENCY-1:1] vld_pipe;
    logic [W-1:0]       dat_pipe [LATENCY-1:1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_pipe <= '0;
      end else begin
        vld_pipe[1] <= issue;
        for (int i = 2; i < LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
      end
    end

    always_ff @(posedge clk) begin
      dat_pipe[1] <= rd_word;
      for (int i = 2; i < LATENCY; i++) dat_pipe[i] <= dat_pipe[i-1];
    end

    assign push      = vld_pipe[LATENCY-1];
    assign push_word = dat_pipe[LATENCY-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
    end else if (issue && !push) begin
      inflight <= inflight + IW'(1);
    end else if (push && !issue) begin
      inflight <= inflight - IW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr] <= push_word;
  end

  assign full          = (count == CW'(RESP_DEPTH));
  assign head          = fifo_q[rptr];
  assign instr_valid_o = (count != '0);
  assign instr_data_o  = instr_valid_o ? head[31:0] : 32'h0;
`ifdef CP_IMEM_ERR_EN
  assign instr_err_o   = instr_valid_o & head[32];
`endif

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));

endmodule

// File: tb/tb_cp_imem_resp.sv
// Randomised bench for cp_imem_resp: two configurations (LATENCY 1/RESP_DEPTH 2 and LATENCY 3/RESP_DEPTH 4)
// checked every cycle against a queue-based model, plus literal expectations for directed scenarios.
module tb_cp_imem_resp;
  logic        clk = 1'b0, rst_n = 1'b0, ready = 1'b0, ld_we = 1'b0;
  logic [31:0] addr = '0, ld_data = '0;
  logic [9:0]  ld_addr = '0;
  logic        vld [2];
  logic [31:0] dat [2];
`ifdef CP_IMEM_ERR_EN
  logic        err [2];
`endif
  int n_cmp = 0, n_bad = 0;

  typedef struct {logic [31:0] d; bit e; int due;} ent_t;

  always #5 clk = ~clk;

  cp_imem_resp #(.LATENCY(1), .RESP_DEPTH(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .instr_ready_i(ready), .instr_addr_i(addr),
    .instr_valid_o(vld[0]), .instr_data_o(dat[0]),
`ifdef CP_IMEM_ERR_EN
    .instr_err_o(err[0]),
`endif
    .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_data_i(ld_data));

  cp_imem_resp #(.LATENCY(3), .RESP_DEPTH(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .instr_ready_i(ready), .instr_addr_i(addr),
    .instr_valid_o(vld[1]), .instr_data_o(dat[1]),
`ifdef CP_IMEM_ERR_EN
    .instr_err_o(err[1]),
`endif
    .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_data_i(ld_data));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h want %08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ready = 1'b0; ld_we = 1'b0;
    cyc1();
    rst_n = 1'b1;
  endtask

  // Model: in-flight words carry the cycle in which they reach the FIFO; FIFO is a plain queue.
  for (genvar k = 0; k < 2; k++) begin : g_m
    localparam int L = (k == 0) ? 1 : 3;
    localparam int R = (k == 0) ? 2 : 4;
    ent_t        fl[$];
    ent_t        q[$];
    int          cyc = 0;
    logic [31:0] mem_m [1024];

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        fl.delete();
        q.delete();
      end else begin
        int   p;
        ent_t ent;
        p = (q.size() > 0 && ready) ? 1 : 0;
        if (ready && (fl.size() + q.size() - p < R)) begin
`ifdef CP_IMEM_ERR_EN
          ent.e = (addr[1:0] != 2'b0) || (addr[31:12] != 20'h0);
`else
          ent.e = 1'b0;
`endif
          ent.d   = ent.e ? 32'h0 : mem_m[addr[11:2]];
          ent.due = cyc + L - 1;
          fl.push_back(ent);
        end
        if (p != 0) void'(q.pop_front());
        while (fl.size() > 0 && fl[0].due == cyc) q.push_back(fl.pop_front());
        if (ld_we) mem_m[ld_addr] = ld_data;
        cyc++;
      end
    end

    always @(negedge clk) begin
      if (rst_n) begin
        chk($sformatf("valid%0d", k), 32'(vld[k]), 32'(q.size() > 0));
        chk($sformatf("data%0d", k), dat[k], (q.size() > 0) ? q[0].d : 32'h0);
`ifdef CP_IMEM_ERR_EN
        chk($sformatf("err%0d", k), 32'(err[k]), (q.size() > 0) ? 32'(q[0].e) : 32'h0);
`endif
      end
    end
  end

  logic [31:0] ex [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
`ifdef CP_IMEM_ERR_EN
  logic [31:0] wrap_exp = 32'h0;
`else
  logic [31:0] wrap_exp = 32'h22;
`endif

  initial begin
    #12;
    chk("rst_v0", 32'(vld[0]), 32'h0);
    chk("rst_d0", dat[0], 32'h0);
    chk("rst_v1", 32'(vld[1]), 32'h0);
    chk("rst_d1", dat[1], 32'h0);
    cyc1();
    rst_n = 1'b1;

    // Preload the whole memory through the load port.
    for (int i = 0; i < 1024; i++) begin
      ld_we = 1'b1; ld_addr = 10'(i);
      ld_data = (i < 4) ? ex[i] : (i == 5) ? 32'hAAAA0000 : $urandom;
      cyc1();
    end
    ld_we = 1'b0;

    // Back-to-back stream.
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      addr = 32'(i * 4);
      cyc1();
      @(negedge clk);
      chk("seq_v", 32'(vld[0]), 32'h1);
      chk("seq_d", dat[0], ex[i]);
      if (i == 1) chk("lat3_not_yet", 32'(vld[1]), 32'h0);
      if (i == 2) begin
        chk("lat3_v", 32'(vld[1]), 32'h1);
        chk("lat3_d", dat[1], 32'h11);
      end
    end
    ready = 1'b0;

    // Backpressure.
    do_reset();
    ready = 1'b1; addr = 32'h0;
    cyc1();
    addr = 32'h4;
    cyc1();
    ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold0", dat[0], 32'h22);
      cyc1();
    end
    @(negedge clk);
    chk("bp_v1", 32'(vld[1]), 32'h1);
    chk("bp_d1", dat[1], 32'h11);
    ready = 1'b1; addr = 32'h8;
    cyc1();
    @(negedge clk);
    chk("bp_rel0", dat[0], 32'h33);
    chk("bp_rel1", dat[1], 32'h22);
    ready = 1'b0;

    // Load/read collision on the same word.
    do_reset();
    ld_we = 1'b1; ld_addr = 10'd5; ld_data = 32'h5555FFFF;
    ready = 1'b1; addr = 32'h14;
    cyc1();
    ld_we = 1'b0;
    @(negedge clk);
    chk("coll_old", dat[0], 32'hAAAA0000);
    cyc1();
    @(negedge clk);
    chk("coll_new", dat[0], 32'h5555FFFF);
    ready = 1'b0;

    // Address wrap.
    do_reset();
    ready = 1'b1; addr = 32'h00001004;
    cyc1();
    ready = 1'b0;
    @(negedge clk);
    chk("wrap", dat[0], wrap_exp);
`ifdef CP_IMEM_ERR_EN
    chk("wrap_err", 32'(err[0]), 32'h1);
`endif

    // Reset with two words buffered and one in flight.
    do_reset();
    ready = 1'b1;
    addr = 32'h0; cyc1();
    addr = 32'h4; cyc1();
    addr = 32'h8; cyc1();
    ready = 1'b0;
    cyc1();
    @(negedge clk);
    chk("pre_rst_d1", dat[1], 32'h11);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_v1", 32'(vld[1]), 32'h0);
    chk("mid_rst_d1", dat[1], 32'h0);
    chk("mid_rst_v0", 32'(vld[0]), 32'h0);
    cyc1();
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("no_stale", 32'(vld[1]), 32'h0);
      cyc1();
    end

    // Random traffic.
    repeat (3000) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        ready   = ($urandom_range(0, 9) < 7);
        addr    = ($urandom_range(0, 7) == 0) ? $urandom : (32'($urandom_range(0, 63)) << 2);
        ld_we   = ($urandom_range(0, 4) == 0);
        ld_addr = 10'($urandom_range(0, 63));
        ld_data = $urandom;
        cyc1();
      end
    end
    ready = 1'b0; ld_we = 1'b0;
    cyc1();
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
